shift_result_stage: RTL and testbench

SHIFT_RESULT_STAGE -- requirements
Module: shift_result_stage

---
 rtl/shift_result_stage.sv | 121 ++++++++++++
 tb/tb_shift_result_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/shift_result_stage.sv
// Shift result stage: selects the shifter output for OP, derives flags, and buffers results in a 2-entry FIFO.
// Latency 1 cycle into an empty buffer; in_ready drops when both entries are occupied (no path from out_ready).
module shift_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z_SLL,
  input  logic [WIDTH-1:0] Z_SRL,
  input  logic [WIDTH-1:0] Z_SRA,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             ZERO,
  output logic             NEG,
  output logic             CARRY,
  output logic             ERR,
  output logic [7:0]       err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             err;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [1:0] CAP = DEPTH[1:0];

  state_t state, state_nxt;
  entry_t ent0, ent1, new_ent;
  logic   push, pop;

  // N > 32 covers Y[31]=1 (N treated as 255) as well as any large unsigned amount
  logic       amt_big;
  logic       amt_nz;
  logic [4:0] sll_idx;
  logic [4:0] srx_idx;

  assign amt_big = Y[31] | (|Y[30:6]) | (Y[5] & (|Y[4:0]));
  assign amt_nz  = |Y;
  assign sll_idx = 5'(6'd32 - Y[5:0]);
  assign srx_idx = 5'(Y[5:0] - 6'd1);

  always_comb begin
    new_ent = '0;
    case (OP)
      2'b00: begin
        new_ent.r     = Z_SLL;
        new_ent.carry = amt_nz && !amt_big && X[sll_idx];
      end
      2'b01: begin
        new_ent.r     = Z_SRL;
        new_ent.carry = amt_nz && !amt_big && X[srx_idx];
      end
      2'b10: begin
        new_ent.r     = Z_SRA;
        new_ent.carry = amt_big ? X[WIDTH-1] : (amt_nz && X[srx_idx]);
      end
      default: new_ent.err = 1'b1;
    endcase
    new_ent.zero = (new_ent.r == '0);
    new_ent.neg  = new_ent.r[WIDTH-1];
  end

  assign in_ready  = !rst && (state < CAP);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE:     if (push && !pop) state_nxt = FULL;
               else if (pop && !push) state_nxt = EMPTY;
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // ent0 is always the head; a push alongside a pop in ONE lands straight in ent0
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      if (state == FULL && pop) ent0 <= ent1;
      if (push) begin
        if (state == EMPTY || (state == ONE && pop)) ent0 <= new_ent;
        else                                         ent1 <= new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                        err_count <= '0;
    else if (push && OP == 2'b11 && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

  assign R     = out_valid ? ent0.r     : '0;
  assign ZERO  = out_valid && ent0.zero;
  assign NEG   = out_valid && ent0.neg;
  assign CARRY = out_valid && ent0.carry;
  assign ERR   = out_valid && ent0.err;

endmodule

// File: tb/tb_shift_result_stage.sv
// Bench for shift_result_stage: directed scenarios plus random traffic, checked against a queue-based reference model.
module tb_shift_result_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  OP;
  logic [31:0] X, Y, Z_SLL, Z_SRL, Z_SRA, R;
  logic        ZERO, NEG, CARRY, ERR;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        zero, neg, carry, err;
  } ent_t;

  ent_t q[$];
  int   errc = 0;

  always #5 clk = ~clk;

  shift_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .OP(OP), .X(X), .Y(Y), .Z_SLL(Z_SLL), .Z_SRL(Z_SRL), .Z_SRA(Z_SRA),
    .out_valid(out_valid), .out_ready(out_ready), .R(R),
    .ZERO(ZERO), .NEG(NEG), .CARRY(CARRY), .ERR(ERR), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the carry is the bit that falls just past the 32-bit window after a wide shift
  function automatic ent_t ref_ent(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    ent_t        e;
    int unsigned n;
    logic [32:0] t;
    n = y[31] ? 255 : y;
    e = '0;
    case (op)
      2'b00: begin e.r = x << n; t = {1'b0, x} << n; e.carry = t[32]; end
      2'b01: begin e.r = x >> n; t = {x, 1'b0} >> n; e.carry = t[0]; end
      2'b10: begin e.r = $signed(x) >>> n; t = 33'($signed({x, 1'b0}) >>> n); e.carry = t[0]; end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.r == 32'd0);
    e.neg  = e.r[31];
    return e;
  endfunction

  task automatic step(input logic r, input logic iv, input logic [1:0] op,
                      input logic [31:0] x, input logic [31:0] y, input logic ordy,
                      output logic acc);
    ent_t h;
    logic pop;
    @(negedge clk);
    rst = r; in_valid = iv; OP = op; X = x; Y = y; out_ready = ordy;
    Z_SLL = x << y;
    Z_SRL = x >> y;
    Z_SRA = $signed(x) >>> y;
    #1;
    h = (q.size() > 0) ? q[0] : '0;
    chk("in_ready",  32'(in_ready),  32'(!r && q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("R",         R,              h.r);
    chk("flags",     {28'd0, ZERO, NEG, CARRY, ERR}, {28'd0, h.zero, h.neg, h.carry, h.err});
    chk("err_count", 32'(err_count), 32'(errc));
    acc = !r && iv && q.size() < 2;
    pop = !r && ordy && q.size() > 0;
    @(posedge clk);
    if (r) begin
      q.delete();
      errc = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_ent(op, x, y));
        if (op == 2'b11 && errc < 255) errc++;
      end
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] y;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; OP = '0;
    X = '0; Y = '0; Z_SLL = '0; Z_SRL = '0; Z_SRA = '0;
    @(posedge clk);
    step(1, 1, 0, 32'h1, 32'h1, 1, acc);
    chk("rst_no_accept", 32'(acc), 0);

    // SRA of a negative operand, accepted on the first edge out of reset
    step(0, 1, 2'b10, 32'h8000_0000, 32'd4, 1, acc);
    chk("first_accept", 32'(acc), 1);
    #1;
    chk("sra_r", R, 32'hF800_0000);
    chk("sra_flags", {NEG, ZERO, CARRY}, 3'b100);

    step(0, 1, 2'b00, 32'h1, 32'd32, 1, acc);
    #1;
    chk("sll32_r", R, 32'h0);
    chk("sll32_flags", {ZERO, CARRY}, 2'b11);

    step(0, 1, 2'b10, 32'h8000_0001, 32'hFFFF_FFFF, 1, acc);
    #1;
    chk("sra_neg_r", R, 32'hFFFF_FFFF);
    chk("sra_neg_flags", {CARRY, NEG}, 2'b11);
    step(0, 0, 0, 0, 0, 1, acc);

    // Backpressure: A and B fill the buffer, C waits until space appears
    step(0, 1, 2'b01, 32'hAAAA_0000, 32'd4, 0, acc);
    step(0, 1, 2'b01, 32'hBBBB_0000, 32'd8, 0, acc);
    step(0, 1, 2'b01, 32'hCCCC_0000, 32'd12, 0, acc);
    chk("c_waits", 32'(acc), 0);
    chk("c_waits_rdy", 32'(in_ready), 0);
    for (int i = 0; i < 4 && !acc; i++) step(0, 1, 2'b01, 32'hCCCC_0000, 32'd12, 1, acc);
    chk("c_accepted", 32'(acc), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, acc);

    // Steady push+pop with one entry resident
    step(0, 1, 2'b00, 32'h1234_5678, 32'd1, 0, acc);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 2'(i % 3), $urandom, 32'($urandom_range(0, 40)), 1, acc);
      #1;
      chk("pp_valid", 32'(out_valid), 1);
      chk("pp_ready", 32'(in_ready), 1);
    end
    step(0, 0, 0, 0, 0, 1, acc);

    // Reserved op until the error counter saturates
    for (int i = 0; i < 300; i++) step(0, 1, 2'b11, $urandom, $urandom, 1, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("err_sat", 32'(err_count), 255);
    step(0, 1, 2'b11, 32'h5, 32'h1, 0, acc);
    step(0, 1, 2'b00, 32'h5, 32'h1, 0, acc);
    chk("full_rdy", 32'(in_ready), 0);
    step(1, 0, 0, 0, 0, 0, acc);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err_count), 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       y = 32'($urandom_range(0, 40));
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom;
        default: y = 32'($urandom_range(0, 300));
      endcase
      step(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), $urandom, y,
           1'($urandom), acc);
    end
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 0, 0, 1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
